pdl_stack_ctl: RTL and testbench
================================

# pdl_stack_ctl

Pointer/index controller that sits directly upstream of the 1k×32 PDL (push-down list) RAM. It owns the 10-bit PDL pointer and PDL index registers and turns push, pop and indexed read/write commands into RAM address, write-data and read/write enables. It absorbs the RAM's one-cycle read latency through a valid/ready command and response handshake. Pointer, index and overflow state are exported to the datapath.

## Interface
- DEPTH_LOG2, 10: address width; the stack holds 2**DEPTH_LOG2 words.
- WIDTH, 32: data word width.

- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_op  in  2  command: 00 push, 01 pop, 10 index read, 11 index write.
- cmd_data  in  WIDTH  write data for push and index write.
- ptr_load  in  1  load pointer from load_val.
- idx_load  in  1  load index from load_val.
- load_val  in  DEPTH_LOG2  load value.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the read data.
- rsp_data  out  WIDTH  read data.
- pdl_ptr  out  DEPTH_LOG2  current pointer.
- pdl_idx  out  DEPTH_LOG2  current index.
- overflow  out  1  sticky limit flag; present only with PDL_LIMIT_TRAP_EN, tied 0 otherwise.
- ram_addr  out  DEPTH_LOG2  RAM address.
- ram_wdata  out  WIDTH  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_rden  out  1  RAM read enable.
- ram_q  in  WIDTH  RAM read data, valid one cycle after ram_rden.

## Operation
- FSM states: IDLE, RD_WAIT, RSP.
- IDLE: cmd_ready=1.
  - push: ram_addr=ptr+1, ram_wren=1, ptr<=ptr+1; stays IDLE.
  - index write: ram_addr=idx, ram_wren=1; stays IDLE.
  - pop: ram_addr=ptr, ram_rden=1, ptr<=ptr-1; go to RD_WAIT.
  - index read: ram_addr=idx, ram_rden=1; go to RD_WAIT.
- RD_WAIT: cmd_ready=0; rsp_data<=ram_q; go to RSP.
- RSP: rsp_valid=1, cmd_ready=0; rsp_data is held stable; rsp_ready returns the FSM to IDLE.
- ram_wdata=cmd_data in every cycle.
- All strobes (ram_wren, ram_rden) are 0 outside an accepted command.
- Pointer arithmetic is modulo 2**DEPTH_LOG2:
  - push at ptr=1023 writes address 0 and sets ptr to 0.
  - pop at ptr=0 reads address 0 and sets ptr to 1023.
- ptr_load and idx_load are honoured in any state.
  - ptr_load coincident with an accepted push or pop: the load wins and the pointer update is dropped. The RAM access still uses the pre-load pointer.
  - idx_load takes effect the next cycle.
- Push then pop of the same slot in back-to-back cycles is legal. The RAM write lands at the edge where the read issues, so no forwarding is needed.

## Timing
- Reset: all outputs 0; ptr=0, idx=0, overflow=0; FSM=IDLE; cmd_ready rises on the first clk after reset_n deasserts.
- Writes: accepted and issued in the same cycle; one per cycle sustained.
- Reads: accepted in cycle N, ram_q sampled in cycle N+1, rsp_valid high from cycle N+2 until the cycle rsp_ready is high. The next command is accepted no earlier than the cycle after the handshake. Best-case read throughput is 1 per 3 cycles.
- Reset mid-read: the response is discarded and rsp_valid drops immediately (asynchronous).

## Configuration
- PDL_LIMIT_TRAP_EN defined:
  - A push at ptr=2**DEPTH_LOG2-1 or a pop at ptr=0 is still accepted, but it performs no RAM access and leaves ptr unchanged.
  - That push or pop sets overflow, which stays set until ptr_load or reset.
  - A trapped pop returns rsp_data=0 with normal read timing.
- PDL_LIMIT_TRAP_EN undefined: plain modulo wrap; overflow is constant 0.

## Test plan
- Reset, then push 0x11111111, 0x22222222, 0x33333333 -> RAM writes at addresses 1, 2, 3 and ptr=3; three pops return 0x33333333, 0x22222222, 0x11111111, each with rsp_valid at cycle N+2, and ptr=0.
- idx_load 0x155, index write 0xDEADBEEF, index read -> rsp_data=0xDEADBEEF; ptr unchanged.
- Response backpressure: rsp_ready held low for 5 cycles after a pop -> rsp_data stable, cmd_ready=0, no RAM strobes.
- ptr_load 1023 then push 0xA5A5A5A5:
  - Macro off: write at address 0, ptr=0.
  - Macro on: no write, ptr=1023, overflow=1; a later ptr_load 5 clears overflow.
- Pop at ptr=0:
  - Macro off: read at address 0, ptr=1023.
  - Macro on: rsp_data=0, overflow=1.
- reset_n asserted in RD_WAIT -> rsp_valid never rises, ptr=0, cmd_ready=1 on the first clk after release.

Source files
------------

// File: rtl/pdl_stack_ctl.sv
// pdl_stack_ctl: pointer/index controller in front of the 1k x 32 PDL RAM.
// Turns push/pop/index-read/index-write commands into RAM strobes and
// absorbs the RAM's one-cycle read latency with a valid/ready response.
// Optional feature macro: PDL_LIMIT_TRAP_EN (trap push at top / pop at zero,
// sticky overflow flag). Without it the pointer wraps modulo 2**DEPTH_LOG2.
module pdl_stack_ctl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic                  ptr_load,
  input  logic                  idx_load,
  input  logic [DEPTH_LOG2-1:0] load_val,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [DEPTH_LOG2-1:0] pdl_ptr,
  output logic [DEPTH_LOG2-1:0] pdl_idx,
  output logic                  overflow,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  output logic                  ram_wren,
  output logic                  ram_rden,
  input  logic [WIDTH-1:0]      ram_q
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RSP     = 2'd2
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = '0;
  localparam logic [DEPTH_LOG2-1:0] PTR_MAX  = '1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [WIDTH-1:0]      r_rsp_data;
  logic                  r_trap_rd;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_ovf;

  logic                  w_accept;
  logic                  w_trap_push;
  logic                  w_trap_pop;
  logic [DEPTH_LOG2-1:0] w_ptr_inc;
  logic [DEPTH_LOG2-1:0] w_ptr_dec;
  logic [DEPTH_LOG2-1:0] w_ptr_next;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic                  w_ram_wren;
  logic                  w_ram_rden;
  logic                  w_is_read;
  logic                  w_rd_trap;
  logic                  w_set_ovf;

  // cmd_ready is only ever high in IDLE, so this is the accept strobe
  assign w_accept  = cmd_valid & r_cmd_ready;
  assign w_ptr_inc = r_ptr + PTR_ONE;
  assign w_ptr_dec = r_ptr - PTR_ONE;

`ifdef PDL_LIMIT_TRAP_EN
  assign w_trap_push = (r_ptr == PTR_MAX);
  assign w_trap_pop  = (r_ptr == PTR_ZERO);
`else
  assign w_trap_push = 1'b0;
  assign w_trap_pop  = 1'b0;
`endif

  // Decode an accepted command into RAM strobes, next pointer and read intent
  always_comb begin
    w_ram_addr = PTR_ZERO;
    w_ram_wren = 1'b0;
    w_ram_rden = 1'b0;
    w_ptr_next = r_ptr;
    w_is_read  = 1'b0;
    w_rd_trap  = 1'b0;
    w_set_ovf  = 1'b0;
    if (w_accept) begin
      case (cmd_op)
        2'b00: begin
          if (w_trap_push) begin
            w_set_ovf = 1'b1;
          end else begin
            w_ram_addr = w_ptr_inc;
            w_ram_wren = 1'b1;
            w_ptr_next = w_ptr_inc;
          end
        end
        2'b01: begin
          w_is_read = 1'b1;
          if (w_trap_pop) begin
            w_set_ovf = 1'b1;
            w_rd_trap = 1'b1;
          end else begin
            w_ram_addr = r_ptr;
            w_ram_rden = 1'b1;
            w_ptr_next = w_ptr_dec;
          end
        end
        2'b10: begin
          w_ram_addr = r_idx;
          w_ram_rden = 1'b1;
          w_is_read  = 1'b1;
        end
        2'b11: begin
          w_ram_addr = r_idx;
          w_ram_wren = 1'b1;
        end
        default: begin
          w_ram_addr = PTR_ZERO;
        end
      endcase
    end else begin
      w_ram_addr = PTR_ZERO;
    end
  end

  // Command/response FSM with registered handshake outputs and read capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_trap_rd   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_read) begin
            r_state     <= S_RD_WAIT;
            r_cmd_ready <= 1'b0;
            r_trap_rd   <= w_rd_trap;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          r_rsp_data  <= r_trap_rd ? '0 : ram_q;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Pointer, index and sticky overflow; an explicit load beats any update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= PTR_ZERO;
      r_idx <= PTR_ZERO;
      r_ovf <= 1'b0;
    end else begin
      if (ptr_load) begin
        r_ptr <= load_val;
        r_ovf <= 1'b0;
      end else begin
        r_ptr <= w_ptr_next;
        r_ovf <= r_ovf | w_set_ovf;
      end
      if (idx_load) begin
        r_idx <= load_val;
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign pdl_ptr   = r_ptr;
  assign pdl_idx   = r_idx;
`ifdef PDL_LIMIT_TRAP_EN
  assign overflow  = r_ovf;
`else
  assign overflow  = 1'b0;
`endif
  assign ram_addr  = w_ram_addr;
  assign ram_wdata = cmd_data;
  assign ram_wren  = w_ram_wren;
  assign ram_rden  = w_ram_rden;

endmodule

// File: tb/tb_pdl_stack_ctl.sv
// Self-checking bench for pdl_stack_ctl: directed scenarios plus randomized
// command traffic against a transaction-level stack model and a RAM model.
module tb_pdl_stack_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        ptr_load;
  logic        idx_load;
  logic [9:0]  load_val;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [9:0]  pdl_ptr;
  logic [9:0]  pdl_idx;
  logic        overflow;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic        ram_rden;
  logic [31:0] ram_q;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_mem [0:1023];
  int          m_ptr;
  int          m_idx;
  logic        m_ovf;

`ifdef PDL_LIMIT_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // RAM behavioural model
  logic [31:0] ram_mem [0:1023];
  logic        ram_clear;

  pdl_stack_ctl #(.DEPTH_LOG2(10), .WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .ptr_load(ptr_load), .idx_load(idx_load),
    .load_val(load_val), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .pdl_ptr(pdl_ptr), .pdl_idx(pdl_idx), .overflow(overflow),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .ram_rden(ram_rden), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= 32'h0;
      ram_q <= 32'h0;
    end else begin
      if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
      if (ram_rden) ram_q <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".ptr"}, {22'h0, pdl_ptr}, m_ptr);
    chk({tag, ".idx"}, {22'h0, pdl_idx}, m_idx);
    chk({tag, ".ovf"}, {31'h0, overflow}, {31'h0, m_ovf});
  endtask

  task automatic do_push(input logic [31:0] d);
    bit trap;
    trap = TRAP && (m_ptr == 1023);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = d;
    #1;
    chk("push.ready", {31'h0, cmd_ready}, 32'h1);
    chk("push.wren", {31'h0, ram_wren}, {31'h0, !trap});
    chk("push.rden", {31'h0, ram_rden}, 32'h0);
    chk("push.wdata", ram_wdata, d);
    if (!trap) chk("push.addr", {22'h0, ram_addr}, (m_ptr + 1) % 1024);
    tick();
    cmd_valid = 1'b0;
    if (trap) m_ovf = 1'b1;
    else begin
      m_ptr = (m_ptr + 1) % 1024;
      m_mem[m_ptr] = d;
    end
    chk_state("push");
  endtask

  task automatic do_idx_write(input logic [31:0] d);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = d;
    #1;
    chk("iwr.wren", {31'h0, ram_wren}, 32'h1);
    chk("iwr.addr", {22'h0, ram_addr}, m_idx);
    tick();
    cmd_valid = 1'b0;
    m_mem[m_idx] = d;
    chk_state("iwr");
  endtask

  // pop (is_pop=1) or index read, with 'hold' cycles of response backpressure
  task automatic do_read(input bit is_pop, input int hold);
    bit          trap;
    int          addr;
    logic [31:0] exp;
    trap = is_pop && TRAP && (m_ptr == 0);
    addr = is_pop ? m_ptr : m_idx;
    exp  = trap ? 32'h0 : m_mem[addr];
    cmd_valid = 1'b1; cmd_op = is_pop ? 2'b01 : 2'b10; cmd_data = $urandom;
    #1;
    chk("rd.ready", {31'h0, cmd_ready}, 32'h1);
    chk("rd.rden", {31'h0, ram_rden}, {31'h0, !trap});
    chk("rd.wren", {31'h0, ram_wren}, 32'h0);
    if (!trap) chk("rd.addr", {22'h0, ram_addr}, addr);
    tick();
    if (is_pop) begin
      if (trap) m_ovf = 1'b1;
      else m_ptr = (m_ptr + 1023) % 1024;
    end
    // a new command is offered while busy; it must not be taken
    cmd_op = 2'b00;
    #1;
    chk("rd.n1_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rd.n1_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rd.n1_wren", {31'h0, ram_wren}, 32'h0);
    tick();
    chk("rd.n2_valid", {31'h0, rsp_valid}, 32'h1);
    chk("rd.data", rsp_data, exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("bp.valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp.data", rsp_data, exp);
      chk("bp.ready", {31'h0, cmd_ready}, 32'h0);
      chk("bp.strobes", {30'h0, ram_wren, ram_rden}, 32'h0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd.done_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rd.done_ready", {31'h0, cmd_ready}, 32'h1);
    chk_state("rd");
  endtask

  task automatic do_ptr_load(input logic [9:0] v);
    ptr_load = 1'b1; load_val = v;
    tick();
    ptr_load = 1'b0;
    m_ptr = v; m_ovf = 1'b0;
    chk_state("pload");
  endtask

  task automatic do_idx_load(input logic [9:0] v);
    idx_load = 1'b1; load_val = v;
    tick();
    idx_load = 1'b0;
    m_idx = v;
    chk_state("iload");
  endtask

  initial begin
    reset_n = 1'b0; ram_clear = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 32'h0;
    ptr_load = 1'b0; idx_load = 1'b0; load_val = 10'h0; rsp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
    m_ptr = 0; m_idx = 0; m_ovf = 1'b0;
    tick(); tick();
    ram_clear = 1'b0;
    chk("rst.cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst.rsp_data", rsp_data, 32'h0);
    chk("rst.strobes", {30'h0, ram_wren, ram_rden}, 32'h0);
    chk("rst.addr", {22'h0, ram_addr}, 32'h0);
    chk_state("rst");
    reset_n = 1'b1;
    #1;
    chk("rel.ready_low", {31'h0, cmd_ready}, 32'h0);
    tick();
    chk("rel.ready_high", {31'h0, cmd_ready}, 32'h1);

    // push three, pop three
    do_push(32'h11111111);
    do_push(32'h22222222);
    do_push(32'h33333333);
    chk("seq.ram1", ram_mem[1], 32'h11111111);
    chk("seq.ram3", ram_mem[3], 32'h33333333);
    do_read(1'b1, 0);
    do_read(1'b1, 0);
    do_read(1'b1, 0);
    chk("seq.ptr0", {22'h0, pdl_ptr}, 32'h0);

    // indexed access
    do_idx_load(10'h155);
    do_idx_write(32'hDEADBEEF);
    do_read(1'b0, 0);
    chk("idx.ram", ram_mem[10'h155], 32'hDEADBEEF);

    // backpressure
    do_push(32'hCAFEF00D);
    do_read(1'b1, 5);

    // pop at zero (wrap or trap)
    do_read(1'b1, 1);

    // push at top (wrap or trap)
    do_ptr_load(10'd1023);
    do_push(32'hA5A5A5A5);
    do_ptr_load(10'd5);

    // ptr_load coincident with push: RAM uses old pointer, load wins
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 32'h5A5A0001;
    ptr_load = 1'b1; load_val = 10'd77;
    #1;
    chk("coinc.wren", {31'h0, ram_wren}, 32'h1);
    chk("coinc.addr", {22'h0, ram_addr}, 32'd6);
    tick();
    cmd_valid = 1'b0; ptr_load = 1'b0;
    m_mem[6] = 32'h5A5A0001; m_ptr = 77; m_ovf = 1'b0;
    chk_state("coinc");

    // back-to-back push then pop of the same slot
    do_push(32'h0BADF00D);
    do_read(1'b1, 0);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: do_push($urandom);
        3, 4:    do_read(1'b1, $urandom_range(0, 3));
        5:       do_idx_write($urandom);
        6:       do_read(1'b0, $urandom_range(0, 2));
        7:       do_idx_load(10'($urandom));
        8:       do_ptr_load(($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 2))
                                                         : 10'($urandom_range(1021, 1023)));
        default: tick();
      endcase
    end

    // reset during RD_WAIT
    do_push(32'h77777777);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    tick();
    cmd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    m_ptr = 0; m_idx = 0; m_ovf = 1'b0;
    chk("mrst.valid", {31'h0, rsp_valid}, 32'h0);
    chk("mrst.ready", {31'h0, cmd_ready}, 32'h0);
    chk_state("mrst");
    tick();
    chk("mrst.valid2", {31'h0, rsp_valid}, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("mrst.rel_ready_low", {31'h0, cmd_ready}, 32'h0);
    tick();
    chk("mrst.rel_ready", {31'h0, cmd_ready}, 32'h1);
    chk("mrst.rel_valid", {31'h0, rsp_valid}, 32'h0);
    tick();
    chk("mrst.still_valid", {31'h0, rsp_valid}, 32'h0);
    chk_state("mrst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
